// File: rtl/conv1d_ctrl_pkg.sv
// Shared definitions for the conv1d control/status register block:
// register byte offsets, bit positions used by write decode, and packed
// layouts of the CTRL and STATUS read words.
package conv1d_ctrl_pkg;

  // Byte offsets of the mapped registers
  localparam int CTRL_OFFS   = 'h00;
  localparam int STATUS_OFFS = 'h04;
  localparam int IRQ_OFFS    = 'h08;
  localparam int CYCLES_OFFS = 'h0C;
  localparam int RUNS_OFFS   = 'h10;

  // Write-side bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_SRST_BIT  = 1;
  localparam int CTRL_IRQEN_BIT = 2;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int IRQ_PEND_BIT   = 0;

  // CTRL read layout (START/SOFT_RST are pulse bits and always read 0)
  typedef struct packed {
    logic irq_en;
    logic soft_rst;
    logic start;
  } ctrl_t;

  // STATUS read layout
  typedef struct packed {
    logic srst_act;
    logic busy_err;
    logic done;
    logic running;
  } status_t;

endpackage

// File: rtl/conv1d_ctrl_regs.sv
// Control/status register block for the conv1d accelerator.
// Host side: word-addressed request port, granted same cycle, response one
// cycle later (rdata=0 for writes, unmapped reads return 0).
// Accelerator side: start pulse, active-low soft reset held for RstCycles,
// done/running status in; level interrupt out (PENDING & IRQ_EN, registered).
// Ports:
//   clk_i, rst_i (async, active-high)
//   reg_req_i/reg_we_i/reg_addr_i/reg_wdata_i -> reg_gnt_o/reg_rvalid_o/reg_rdata_o
//   start_o, soft_rst_no, done_i, done_e_i, running_i, running_e_i, irq_o
module conv1d_ctrl_regs
  import conv1d_ctrl_pkg::*;
#(
  parameter int AddrWidth = 5,
  parameter int RstCycles = 4,
  parameter int CntWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_req_i,
  input  logic                 reg_we_i,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  output logic                 reg_gnt_o,
  output logic                 reg_rvalid_o,
  output logic [31:0]          reg_rdata_o,
  output logic                 start_o,
  output logic                 soft_rst_no,
  input  logic                 done_i,
  input  logic                 done_e_i,
  input  logic                 running_i,
  input  logic                 running_e_i,
  output logic                 irq_o
);

  localparam int RstW = $clog2(RstCycles + 1);

  logic [RstW-1:0]     r_srst_cnt;
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] r_cycles;
  logic [15:0]         r_runs;
  logic                r_start, r_done, r_busy, r_pend, r_irq_en, r_irq;
  logic                r_rvalid;
  logic [31:0]         r_rdata;

  logic [AddrWidth-1:0] w_addr;
  logic w_wr, w_rd, w_sel_ctrl, w_sel_stat, w_sel_irq;
  logic w_srst_req, w_start_req, w_srst_act, w_start_ok, w_start_rej;
  logic w_stat_rd, w_busy_clr, w_pend_clr;
  logic [31:0] w_rmux;
  status_t w_stat;
  ctrl_t   w_ctrl;
  logic w_unused_ok;

  assign w_addr     = {reg_addr_i[AddrWidth-1:2], 2'b00};
  assign w_wr       = reg_req_i & reg_we_i;
  assign w_rd       = reg_req_i & ~reg_we_i;
  assign w_sel_ctrl = (w_addr == AddrWidth'(CTRL_OFFS));
  assign w_sel_stat = (w_addr == AddrWidth'(STATUS_OFFS));
  assign w_sel_irq  = (w_addr == AddrWidth'(IRQ_OFFS));

  assign w_srst_req  = w_wr & w_sel_ctrl & reg_wdata_i[CTRL_SRST_BIT];
  assign w_start_req = w_wr & w_sel_ctrl & reg_wdata_i[CTRL_START_BIT];
  assign w_srst_act  = (r_srst_cnt != '0);
  // A soft-reset request in the same write beats START
  assign w_start_ok  = w_start_req & ~running_i & ~w_srst_act & ~w_srst_req;
  assign w_start_rej = w_start_req & ~w_start_ok;
  assign w_stat_rd   = w_rd & w_sel_stat;
  assign w_busy_clr  = w_wr & w_sel_stat & reg_wdata_i[STAT_BUSY_BIT];
  assign w_pend_clr  = w_wr & w_sel_irq & reg_wdata_i[IRQ_PEND_BIT];

  assign w_stat = '{srst_act: w_srst_act, busy_err: r_busy, done: r_done, running: running_i};
  assign w_ctrl = '{irq_en: r_irq_en, soft_rst: 1'b0, start: 1'b0};

  always_comb begin
    w_rmux = '0;
    case (w_addr)
      AddrWidth'(CTRL_OFFS):   w_rmux[2:0] = w_ctrl;
      AddrWidth'(STATUS_OFFS): w_rmux[3:0] = w_stat;
      AddrWidth'(IRQ_OFFS):    w_rmux[IRQ_PEND_BIT] = r_pend;
      AddrWidth'(CYCLES_OFFS): w_rmux[CntWidth-1:0] = r_cycles;
      AddrWidth'(RUNS_OFFS):   w_rmux[15:0] = r_runs;
      default:                 w_rmux = '0;
    endcase
  end

  // Bus response: captured from pre-update register values
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= reg_req_i;
      r_rdata  <= w_rd ? w_rmux : '0;
    end
  end

  // Soft-reset down-counter; a new request reloads it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           r_srst_cnt <= '0;
    else if (w_srst_req) r_srst_cnt <= RstW'(RstCycles);
    else if (w_srst_act) r_srst_cnt <= r_srst_cnt - 1'b1;
  end

  // Run cycle counter, saturating
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          r_cnt <= '0;
    else if (w_start_ok)                r_cnt <= '0;
    else if (running_i && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
  end

  // Control and sticky status; done_e_i set beats same-cycle clears
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_start  <= 1'b0;
      r_cycles <= '0;
      r_runs   <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_pend   <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_start <= w_start_ok;
      r_irq   <= r_pend & r_irq_en;
      if (w_wr && w_sel_ctrl) r_irq_en <= reg_wdata_i[CTRL_IRQEN_BIT];
      if (done_e_i) begin
        r_cycles <= r_cnt;
        r_runs   <= r_runs + 16'd1;
      end
      if (done_e_i)                     r_done <= 1'b1;
      else if (w_start_ok || w_stat_rd) r_done <= 1'b0;
      if (w_start_rej)     r_busy <= 1'b1;
      else if (w_busy_clr) r_busy <= 1'b0;
      if (done_e_i)        r_pend <= 1'b1;
      else if (w_pend_clr) r_pend <= 1'b0;
    end
  end

  assign reg_gnt_o    = reg_req_i;
  assign reg_rvalid_o = r_rvalid;
  assign reg_rdata_o  = r_rdata;
  assign start_o      = r_start;
  assign soft_rst_no  = ~w_srst_act;
  assign irq_o        = r_irq;

  // Inputs and address/data bits that carry no function here
  assign w_unused_ok = ^{done_i, running_e_i, reg_addr_i[1:0], reg_wdata_i[31:3]};

endmodule
